// File: rtl/four_12_12_st0_mode_sched.sv
// rtl/four_12_12_st0_mode_sched.sv - stage-0 pass scheduler for forward and error-update passes
//
// Latches the stage geometry for the stage-0 control/data FIFO and decides, at
// each vector boundary, whether the shared stage datapath runs another forward
// vector or an error-update pass. During an error pass it generates the
// error-mode control set consumed by the FIFO controller.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cfg_vld/cfg_rdy       geometry handshake, accepted only in IDLE
//   cfg_load_depth        vectors per frame minus 1
//   cfg_load_length       words per vector minus 1
//   cfg_stop              level, return to IDLE at the next forward boundary
//   load_finish           pulse, end of one vector read
//   error_tap_update_out  pulse, one tap update completed
//   err_req_vld/rdy       error pass request / one-cycle grant (combinational)
//   load_depth/length     registered geometry
//   error_update_*        registered error-mode controls
//   error_finish_tap      registered echo of each counted tap pulse
//   fwd_count             forward vectors completed in the current frame
//   err_pass_done         one-cycle pulse in the last drain cycle
//   busy                  scheduler not idle

module four_12_12_st0_mode_sched #(
  parameter int TAPS      = 12,
  parameter int DRAIN_CYC = 4,
  parameter int MIN_FWD   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_vld,
  output logic       cfg_rdy,
  input  logic [4:0] cfg_load_depth,
  input  logic [3:0] cfg_load_length,
  input  logic       cfg_stop,
  input  logic       load_finish,
  input  logic       error_tap_update_out,
  input  logic       err_req_vld,
  output logic       err_req_rdy,
  output logic [4:0] load_depth,
  output logic [3:0] load_length,
  output logic       error_update_mode,
  output logic       error_update_latch,
  output logic       error_update_first,
  output logic       error_finish_tap,
  output logic [4:0] fwd_count,
  output logic       err_pass_done,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    ERR   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [3:0] TAPS_LAST  = 4'(TAPS);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYC - 1);
  localparam logic [3:0] MIN_GAP    = 4'(MIN_FWD);

  state_t     state_q, state_d;
  logic [4:0] load_depth_q, load_depth_d;
  logic [3:0] load_length_q, load_length_d;
  logic [4:0] fwd_count_q, fwd_count_d;
  logic [3:0] gap_q, gap_d;
  logic [3:0] tap_cnt_q, tap_cnt_d;
  logic [3:0] drain_cnt_q, drain_cnt_d;
  logic       mode_q, mode_d;
  logic       latch_q, latch_d;
  logic       first_q, first_d;
  logic       finish_tap_q, finish_tap_d;
  logic       done_q, done_d;

  logic       err_grant;
  logic [3:0] gap_inc;
  logic [3:0] tap_cnt_inc;

  // The vector that ends at this boundary counts toward the gap, so the
  // grant test uses the already-incremented (saturating) value.
  assign gap_inc     = (gap_q == 4'd15) ? 4'd15 : gap_q + 4'd1;
  assign tap_cnt_inc = tap_cnt_q + 4'd1;

  always_comb begin
    state_d       = state_q;
    load_depth_d  = load_depth_q;
    load_length_d = load_length_q;
    fwd_count_d   = fwd_count_q;
    gap_d         = gap_q;
    tap_cnt_d     = tap_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    finish_tap_d  = 1'b0;
    err_grant     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_vld) begin
          load_depth_d  = cfg_load_depth;
          load_length_d = cfg_load_length;
          fwd_count_d   = 5'd0;
          gap_d         = 4'd0;
          tap_cnt_d     = 4'd0;
          drain_cnt_d   = 4'd0;
          state_d       = FWD;
        end
      end

      FWD: begin
        if (load_finish) begin
          // Wrap after the last vector of the frame; depth 0 pins it at 0.
          fwd_count_d = (fwd_count_q == load_depth_q) ? 5'd0 : fwd_count_q + 5'd1;
          gap_d       = gap_inc;
          if (cfg_stop) begin
            state_d = IDLE;
          end else if (err_req_vld && (gap_inc >= MIN_GAP)) begin
            err_grant = 1'b1;
            gap_d     = 4'd0;
            tap_cnt_d = 4'd0;
            state_d   = ERR;
          end
        end
      end

      ERR: begin
        // load_finish and cfg_stop are deliberately not looked at here.
        if (error_tap_update_out) begin
          finish_tap_d = 1'b1;
          if (tap_cnt_inc == TAPS_LAST) begin
            tap_cnt_d   = 4'd0;
            drain_cnt_d = 4'd0;
            state_d     = DRAIN;
          end else begin
            tap_cnt_d = tap_cnt_inc;
          end
        end
      end

      DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          drain_cnt_d = 4'd0;
          state_d     = FWD;
        end else begin
          drain_cnt_d = drain_cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Mode outputs are registered copies of the next state, so they line up
    // with the state the datapath is actually in.
    mode_d  = (state_d == ERR);
    latch_d = (state_d == ERR) || (state_d == DRAIN);
    first_d = err_grant;
    done_d  = (state_d == DRAIN) && (drain_cnt_d == DRAIN_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      load_depth_q  <= 5'd0;
      load_length_q <= 4'd0;
      fwd_count_q   <= 5'd0;
      gap_q         <= 4'd0;
      tap_cnt_q     <= 4'd0;
      drain_cnt_q   <= 4'd0;
      mode_q        <= 1'b0;
      latch_q       <= 1'b0;
      first_q       <= 1'b0;
      finish_tap_q  <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_depth_q  <= load_depth_d;
      load_length_q <= load_length_d;
      fwd_count_q   <= fwd_count_d;
      gap_q         <= gap_d;
      tap_cnt_q     <= tap_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      mode_q        <= mode_d;
      latch_q       <= latch_d;
      first_q       <= first_d;
      finish_tap_q  <= finish_tap_d;
      done_q        <= done_d;
    end
  end

  assign cfg_rdy            = (state_q == IDLE);
  assign busy               = (state_q != IDLE);
  assign err_req_rdy        = err_grant;
  assign load_depth         = load_depth_q;
  assign load_length        = load_length_q;
  assign error_update_mode  = mode_q;
  assign error_update_latch = latch_q;
  assign error_update_first = first_q;
  assign error_finish_tap   = finish_tap_q;
  assign fwd_count          = fwd_count_q;
  assign err_pass_done      = done_q;

endmodule

// File: tb/tb_four_12_12_st0_mode_sched.sv
// tb/tb_four_12_12_st0_mode_sched.sv - directed self-checking bench for the stage-0 pass scheduler
module tb_four_12_12_st0_mode_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Instance A: default parameters
  logic       cfg_vld, cfg_stop, load_finish, tap, err_req_vld;
  logic [4:0] cfg_depth;
  logic [3:0] cfg_len;
  logic       cfg_rdy, err_req_rdy, mode, latch, first, ftap, done, busy;
  logic [4:0] load_depth, fwd_count;
  logic [3:0] load_length;

  // Instance B: MIN_FWD=2, short passes
  logic       b_cfg_vld, b_cfg_stop, b_load_finish, b_tap, b_err_req_vld;
  logic [4:0] b_cfg_depth;
  logic [3:0] b_cfg_len;
  logic       b_cfg_rdy, b_err_req_rdy, b_mode, b_latch, b_first, b_ftap, b_done, b_busy;
  logic [4:0] b_load_depth, b_fwd_count;
  logic [3:0] b_load_length;

  int total = 0;
  int bad   = 0;

  four_12_12_st0_mode_sched dut (
    .clk(clk), .reset(reset), .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy),
    .cfg_load_depth(cfg_depth), .cfg_load_length(cfg_len), .cfg_stop(cfg_stop),
    .load_finish(load_finish), .error_tap_update_out(tap),
    .err_req_vld(err_req_vld), .err_req_rdy(err_req_rdy),
    .load_depth(load_depth), .load_length(load_length),
    .error_update_mode(mode), .error_update_latch(latch),
    .error_update_first(first), .error_finish_tap(ftap),
    .fwd_count(fwd_count), .err_pass_done(done), .busy(busy)
  );

  four_12_12_st0_mode_sched #(.TAPS(1), .DRAIN_CYC(1), .MIN_FWD(2)) dut_b (
    .clk(clk), .reset(reset), .cfg_vld(b_cfg_vld), .cfg_rdy(b_cfg_rdy),
    .cfg_load_depth(b_cfg_depth), .cfg_load_length(b_cfg_len), .cfg_stop(b_cfg_stop),
    .load_finish(b_load_finish), .error_tap_update_out(b_tap),
    .err_req_vld(b_err_req_vld), .err_req_rdy(b_err_req_rdy),
    .load_depth(b_load_depth), .load_length(b_load_length),
    .error_update_mode(b_mode), .error_update_latch(b_latch),
    .error_update_first(b_first), .error_finish_tap(b_ftap),
    .fwd_count(b_fwd_count), .err_pass_done(b_done), .busy(b_busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if ({cfg_rdy, busy, err_req_rdy, mode, latch, first, ftap, done, load_depth, load_length, fwd_count} !== {1'b1, 21'd0}) begin
      bad++;
      $display("FAIL reset_a got=%b want=%b", {cfg_rdy, busy, err_req_rdy, mode, latch, first, ftap, done, load_depth, load_length, fwd_count}, {1'b1, 21'd0});
    end
    total++;
    if ({b_cfg_rdy, b_busy, b_mode, b_latch, b_done, b_fwd_count} !== {1'b1, 9'd0}) begin
      bad++;
      $display("FAIL reset_b got=%b want=%b", {b_cfg_rdy, b_busy, b_mode, b_latch, b_done, b_fwd_count}, {1'b1, 9'd0});
    end
  endtask

  task automatic test_cfg();
    cfg_vld = 1'b1; cfg_depth = 5'd3; cfg_len = 4'd11;
    #1;
    total++;
    if (cfg_rdy !== 1'b1) begin bad++; $display("FAIL cfg_rdy_idle got=%b want=1", cfg_rdy); end
    tick();
    cfg_vld = 1'b0;
    total++;
    if ({load_depth, load_length, busy, cfg_rdy, fwd_count} !== {5'd3, 4'd11, 1'b1, 1'b0, 5'd0}) begin
      bad++;
      $display("FAIL cfg_latch got=%0d/%0d/%b/%b/%0d want=3/11/1/0/0", load_depth, load_length, busy, cfg_rdy, fwd_count);
    end
  endtask

  task automatic test_fwd_count();
    logic [4:0] exp_cnt [4] = '{5'd1, 5'd2, 5'd3, 5'd0};
    for (int i = 0; i < 4; i++) begin
      load_finish = 1'b1; err_req_vld = 1'b0;
      tick();
      load_finish = 1'b0;
      total++;
      if (fwd_count !== exp_cnt[i] || mode !== 1'b0) begin
        bad++;
        $display("FAIL fwd_count[%0d] got=%0d mode=%b want=%0d mode=0", i, fwd_count, mode, exp_cnt[i]);
      end
    end
  endtask

  task automatic test_err_grant();
    load_finish = 1'b1; err_req_vld = 1'b1;
    #1;
    total++;
    if (err_req_rdy !== 1'b1) begin bad++; $display("FAIL grant_rdy got=%b want=1", err_req_rdy); end
    tick();
    load_finish = 1'b0; err_req_vld = 1'b0;
    total++;
    if ({mode, latch, first, err_req_rdy, fwd_count} !== {4'b1110, 5'd1}) begin
      bad++;
      $display("FAIL grant_enter got=%b%b%b%b cnt=%0d want=1110 cnt=1", mode, latch, first, err_req_rdy, fwd_count);
    end
    tick();
    total++;
    if ({mode, latch, first} !== 3'b110) begin
      bad++;
      $display("FAIL first_one_cycle got=%b%b%b want=110", mode, latch, first);
    end
  endtask

  task automatic test_taps();
    for (int k = 0; k < 12; k++) begin
      tap = 1'b1;
      if (k == 11) load_finish = 1'b1;
      tick();
      tap = 1'b0; load_finish = 1'b0;
      total++;
      if (ftap !== 1'b1) begin bad++; $display("FAIL tap_echo[%0d] got=%b want=1", k, ftap); end
      if (k < 11) begin
        total++;
        if (mode !== 1'b1) begin bad++; $display("FAIL tap_mode[%0d] got=%b want=1", k, mode); end
        tick();
        total++;
        if (ftap !== 1'b0) begin bad++; $display("FAIL tap_echo_low[%0d] got=%b want=0", k, ftap); end
      end else begin
        total++;
        if ({mode, latch, done, fwd_count} !== {3'b010, 5'd1}) begin
          bad++;
          $display("FAIL last_tap got=%b%b%b cnt=%0d want=010 cnt=1", mode, latch, done, fwd_count);
        end
      end
    end
    // Tap pulse during drain is ignored.
    tap = 1'b1;
    tick();
    tap = 1'b0;
    total++;
    if ({ftap, latch, done} !== 3'b010) begin
      bad++;
      $display("FAIL drain_1 got=%b%b%b want=010", ftap, latch, done);
    end
    tick();
    total++;
    if ({latch, done} !== 2'b10) begin bad++; $display("FAIL drain_2 got=%b%b want=10", latch, done); end
    tick();
    total++;
    if ({latch, done} !== 2'b11) begin bad++; $display("FAIL drain_done got=%b%b want=11", latch, done); end
    tick();
    total++;
    if ({latch, done, mode, busy} !== 4'b0001) begin
      bad++;
      $display("FAIL drain_exit got=%b%b%b%b want=0001", latch, done, mode, busy);
    end
  endtask

  task automatic test_stop();
    load_finish = 1'b1; err_req_vld = 1'b1;
    #1;
    total++;
    if (err_req_rdy !== 1'b1) begin bad++; $display("FAIL stop_grant got=%b want=1", err_req_rdy); end
    tick();
    load_finish = 1'b0; err_req_vld = 1'b0; cfg_stop = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tap = 1'b1;
      if (i == 5) load_finish = 1'b1;
      tick();
      load_finish = 1'b0;
    end
    tap = 1'b0;
    total++;
    if ({mode, latch, busy, fwd_count} !== {3'b011, 5'd2}) begin
      bad++;
      $display("FAIL stop_in_err got=%b%b%b cnt=%0d want=011 cnt=2", mode, latch, busy, fwd_count);
    end
    for (int i = 0; i < 4; i++) tick();
    total++;
    if ({busy, cfg_rdy, latch} !== 3'b100) begin
      bad++;
      $display("FAIL stop_deferred got=%b%b%b want=100", busy, cfg_rdy, latch);
    end
    load_finish = 1'b1; err_req_vld = 1'b1;
    #1;
    total++;
    if (err_req_rdy !== 1'b0) begin bad++; $display("FAIL stop_priority got=%b want=0", err_req_rdy); end
    tick();
    load_finish = 1'b0; err_req_vld = 1'b0; cfg_stop = 1'b0;
    total++;
    if ({busy, cfg_rdy, mode} !== 3'b010) begin
      bad++;
      $display("FAIL stop_idle got=%b%b%b want=010", busy, cfg_rdy, mode);
    end
  endtask

  task automatic test_reset_in_err();
    // cfg_vld and load_finish together in IDLE; depth 0 frames.
    cfg_vld = 1'b1; load_finish = 1'b1; cfg_depth = 5'd0; cfg_len = 4'd5;
    tick();
    cfg_vld = 1'b0; load_finish = 1'b0;
    total++;
    if ({load_depth, load_length, busy, fwd_count} !== {5'd0, 4'd5, 1'b1, 5'd0}) begin
      bad++;
      $display("FAIL cfg_with_lf got=%0d/%0d/%b/%0d want=0/5/1/0", load_depth, load_length, busy, fwd_count);
    end
    load_finish = 1'b1; err_req_vld = 1'b1;
    tick();
    load_finish = 1'b0; err_req_vld = 1'b0;
    total++;
    if ({mode, fwd_count} !== {1'b1, 5'd0}) begin
      bad++;
      $display("FAIL depth0_grant got=mode %b cnt %0d want=mode 1 cnt 0", mode, fwd_count);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({cfg_rdy, busy, err_req_rdy, mode, latch, first, ftap, done, load_depth, load_length, fwd_count} !== {1'b1, 21'd0}) begin
      bad++;
      $display("FAIL reset_in_err got=%b want=%b", {cfg_rdy, busy, err_req_rdy, mode, latch, first, ftap, done, load_depth, load_length, fwd_count}, {1'b1, 21'd0});
    end
  endtask

  task automatic test_min_fwd();
    logic exp_rdy [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    b_cfg_vld = 1'b1; b_cfg_depth = 5'd7; b_cfg_len = 4'd2;
    tick();
    b_cfg_vld = 1'b0; b_err_req_vld = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b_load_finish = 1'b1;
      #1;
      total++;
      if (b_err_req_rdy !== exp_rdy[i]) begin
        bad++;
        $display("FAIL min_fwd_grant[%0d] got=%b want=%b", i, b_err_req_rdy, exp_rdy[i]);
      end
      tick();
      b_load_finish = 1'b0;
      if (exp_rdy[i]) begin
        b_tap = 1'b1;
        tick();
        b_tap = 1'b0;
        total++;
        if ({b_mode, b_latch, b_done, b_ftap} !== 4'b0111) begin
          bad++;
          $display("FAIL min_fwd_drain[%0d] got=%b%b%b%b want=0111", i, b_mode, b_latch, b_done, b_ftap);
        end
        tick();
      end
    end
    b_err_req_vld = 1'b0;
    total++;
    if ({b_busy, b_latch, b_fwd_count} !== {2'b10, 5'd6}) begin
      bad++;
      $display("FAIL min_fwd_end got=%b%b cnt=%0d want=10 cnt=6", b_busy, b_latch, b_fwd_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    cfg_vld = 1'b0; cfg_stop = 1'b0; load_finish = 1'b0; tap = 1'b0; err_req_vld = 1'b0;
    cfg_depth = 5'd0; cfg_len = 4'd0;
    b_cfg_vld = 1'b0; b_cfg_stop = 1'b0; b_load_finish = 1'b0; b_tap = 1'b0; b_err_req_vld = 1'b0;
    b_cfg_depth = 5'd0; b_cfg_len = 4'd0;
    tick();
    test_reset();
    test_cfg();
    test_fwd_count();
    test_err_grant();
    test_taps();
    test_stop();
    test_reset_in_err();
    test_min_fwd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/four_12_12_st0_mode_sched.md
Name: four_12_12_st0_mode_sched

Overview:
- Stage-0 pass scheduler. Latches the stage geometry (vector depth, vector length) and drives it to the stage-0 control/data FIFO.
- Arbitrates the shared stage datapath between forward vector passes and error-update passes. Decisions are made only at vector boundaries (load_finish).
- Generates the error-mode control set consumed by the FIFO controller: error_update_mode, error_update_latch, error_update_first, error_finish_tap.

Parameters:
- TAPS, 12, error-tap updates per error pass (range 1..15)
- DRAIN_CYC, 4, cycles error_update_latch is held after the final tap (range 1..15)
- MIN_FWD, 1, forward vectors required between two error grants (range 0..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_vld  in  1  configuration request
- cfg_rdy  out  1  configuration accepted; high only in IDLE
- cfg_load_depth  in  5  vectors per frame minus 1
- cfg_load_length  in  4  words per vector minus 1
- cfg_stop  in  1  level; return to IDLE at the next forward boundary
- load_finish  in  1  pulse from FIFO controller, end of one vector read
- error_tap_update_out  in  1  pulse, one tap update completed
- err_req_vld  in  1  error vector pending from downstream
- err_req_rdy  out  1  error request granted (one-cycle pulse)
- load_depth  out  5  registered geometry to FIFO
- load_length  out  4  registered geometry to FIFO
- error_update_mode  out  1  error pass in progress
- error_update_latch  out  1  error pass plus drain window
- error_update_first  out  1  first cycle of an error pass
- error_finish_tap  out  1  registered echo of a counted tap pulse
- fwd_count  out  5  forward vectors completed in the current frame
- err_pass_done  out  1  one-cycle pulse at the end of DRAIN
- busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE; all outputs 0 except cfg_rdy=1; all counters 0. Reset mid-pass aborts immediately; no done pulse is generated.
- FSM states: IDLE, FWD, ERR, DRAIN. Every output except cfg_rdy, err_req_rdy and busy is registered.
- IDLE:
  - cfg_vld=1 latches cfg_load_depth and cfg_load_length into load_depth and load_length.
  - Clears fwd_count and the gap counter; next state FWD.
  - load_finish and error_tap_update_out are ignored.
- FWD, on load_finish:
  - fwd_count increments; if it equals load_depth it wraps to 0.
  - gap counter increments, saturating at 15.
  - Priority at each boundary: cfg_stop first, then error grant, otherwise stay in FWD.
  - cfg_stop=1 -> IDLE.
  - Else if err_req_vld=1 and gap >= MIN_FWD -> err_req_rdy=1 in the same cycle (combinational), gap cleared, next state ERR.
- ERR:
  - error_update_mode=1 and error_update_latch=1.
  - error_update_first=1 only in the first ERR cycle.
  - Each error_tap_update_out pulse increments tap_cnt (4 bits) and pulses error_finish_tap one cycle later.
  - When the pulse that makes tap_cnt==TAPS arrives: tap_cnt cleared, next state DRAIN.
  - load_finish in ERR does not advance fwd_count.
  - cfg_stop is deferred until the next FWD boundary.
- DRAIN:
  - error_update_mode=0; error_update_latch stays 1 for exactly DRAIN_CYC cycles.
  - Further tap pulses are ignored, and error_finish_tap stays 0 for them.
  - On the last DRAIN cycle: err_pass_done=1, next state FWD.
- Latency:
  - cfg_vld -> busy: 1 cycle.
  - Granting load_finish -> error_update_mode: 1 cycle.
  - Final tap pulse -> error_update_mode low: 1 cycle.
  - Final tap pulse -> error_update_latch low: 1+DRAIN_CYC cycles.
- Simultaneous events:
  - load_finish with cfg_vld in IDLE: cfg_vld wins; load_finish is ignored.
  - The last tap pulse coincident with load_finish: the tap is counted; load_finish is ignored.
- Width rule: load_depth=0 gives single-vector frames, so fwd_count stays 0.

Test Plan:
- Reset, then cfg_vld with depth=3, length=11 -> next cycle load_depth=3, load_length=11, busy=1, cfg_rdy=0.
- Four load_finish pulses with err_req_vld=0 -> fwd_count sequence 1,2,3,0; error_update_mode stays 0.
- err_req_vld=1 at a load_finish -> err_req_rdy pulses in that cycle. Next cycle: error_update_mode=1, latch=1, first=1 for exactly one cycle.
- 12 tap pulses spaced 2 cycles apart -> 12 error_finish_tap pulses, each 1 cycle late. Then: mode low 1 cycle after the 12th pulse; latch low after 4 more cycles; err_pass_done pulses once.
- MIN_FWD=2 with err_req_vld held high -> grants occur at every 2nd forward boundary only, never on consecutive boundaries.
- cfg_stop asserted during ERR -> pass completes, then returns to IDLE at the next FWD load_finish. Separately, reset asserted in ERR -> all outputs 0 next cycle and cfg_rdy=1.
